// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush/forward controller for a 5-stage MIPS pipeline.
//               Sequences load-use stalls, EX/MEM-resolved redirects,
//               data-memory wait states and interrupt drain/vectoring.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int WAIT_MAX     = 64
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic [4:0]  ID_EX_Rs,
    input  logic [4:0]  ID_EX_Rt,
    input  logic        ID_EX_MemRd,
    input  logic [4:0]  ID_EX_RdAdress,
    input  logic        EX_MEM_RegWr,
    input  logic [4:0]  EX_MEM_RdAdress,
    input  logic [2:0]  EX_MEM_PCSrc,
    input  logic        MEM_WB_RegWr,
    input  logic [4:0]  MEM_WB_RdAdress,
    input  logic        MemBusy,
    input  logic        IRQ,
    output logic        PCWr,
    output logic        IF_ID_Wr,
    output logic        ID_EX_Wr,
    output logic        EX_MEM_Wr,
    output logic        MEM_WB_Wr,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Flush,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic        IRQ_Ack,
    output logic        MemTimeout,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_IRQ_DRAIN  = 2'd2,
        ST_IRQ_VECTOR = 2'd3
    } state_t;

    localparam logic [3:0] c_DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] c_WAIT_MAX   = 8'(WAIT_MAX);

    state_t      state_q, state_d;
    logic [3:0]  drain_q, drain_d;
    logic [7:0]  wait_q,  wait_d;
    logic        timeout_q, timeout_d;
    logic [15:0] stall_q, stall_d;

    logic        w_redirect;
    logic        w_load_use;

    assign w_redirect = (EX_MEM_PCSrc != 3'd0);
    assign w_load_use = ID_EX_MemRd && (ID_EX_RdAdress != 5'd0) &&
                        ((ID_EX_RdAdress == IF_ID_Rs) || (ID_EX_RdAdress == IF_ID_Rt));

    // Operand forwarding: the younger result (EX/MEM) wins over MEM/WB.
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (EX_MEM_RegWr && (EX_MEM_RdAdress != 5'd0) && (EX_MEM_RdAdress == ID_EX_Rs))
            ForwardA = 2'b10;
        else if (MEM_WB_RegWr && (MEM_WB_RdAdress != 5'd0) && (MEM_WB_RdAdress == ID_EX_Rs))
            ForwardA = 2'b01;
        if (EX_MEM_RegWr && (EX_MEM_RdAdress != 5'd0) && (EX_MEM_RdAdress == ID_EX_Rt))
            ForwardB = 2'b10;
        else if (MEM_WB_RegWr && (MEM_WB_RdAdress != 5'd0) && (MEM_WB_RdAdress == ID_EX_Rt))
            ForwardB = 2'b01;
        if (!Reset) begin
            ForwardA = 2'b00;
            ForwardB = 2'b00;
        end
    end

    // Pipeline enables/flushes and next-state selection.
    always_comb begin
        PCWr         = 1'b1;
        IF_ID_Wr     = 1'b1;
        ID_EX_Wr     = 1'b1;
        EX_MEM_Wr    = 1'b1;
        MEM_WB_Wr    = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        IRQ_Ack      = 1'b0;
        state_d      = state_q;
        drain_d      = drain_q;
        wait_d       = 8'd0;
        timeout_d    = timeout_q;

        if (MemBusy) begin
            // Freeze the whole pipe; interrupt sequencing pauses in place.
            PCWr      = 1'b0;
            IF_ID_Wr  = 1'b0;
            ID_EX_Wr  = 1'b0;
            EX_MEM_Wr = 1'b0;
            MEM_WB_Wr = 1'b0;
            wait_d    = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
            if (wait_d >= c_WAIT_MAX)
                timeout_d = 1'b1;
            if ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT))
                state_d = ST_MEM_WAIT;
        end else begin
            case (state_q)
                ST_IRQ_DRAIN: begin
                    PCWr        = 1'b0;
                    IF_ID_Flush = 1'b1;
                    if (drain_q == 4'd0)
                        state_d = ST_IRQ_VECTOR;
                    else
                        drain_d = drain_q - 4'd1;
                end
                ST_IRQ_VECTOR: begin
                    IRQ_Ack     = 1'b1;
                    IF_ID_Flush = 1'b1;
                    state_d     = ST_RUN;
                end
                default: begin
                    // RUN, and the first ready cycle after a memory wait.
                    state_d = ST_RUN;
                    if (w_redirect) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Flush  = 1'b1;
                        EX_MEM_Flush = 1'b1;
                    end else if (IRQ && !w_load_use) begin
                        PCWr         = 1'b0;
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Flush  = 1'b1;
                        EX_MEM_Flush = 1'b1;
                        state_d      = ST_IRQ_DRAIN;
                        drain_d      = c_DRAIN_INIT;
                    end else if (w_load_use) begin
                        PCWr        = 1'b0;
                        IF_ID_Wr    = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
            endcase
        end

        if (!Reset) begin
            PCWr         = 1'b0;
            IF_ID_Wr     = 1'b0;
            ID_EX_Wr     = 1'b0;
            EX_MEM_Wr    = 1'b0;
            MEM_WB_Wr    = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            IRQ_Ack      = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_d = stall_q;
        if (Reset && !PCWr && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_RUN;
            drain_q   <= 4'd0;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
            stall_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Scoreboard bench for pipe_hazard_ctrl. Each driven cycle
//               pushes its expected outputs; a negedge monitor pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    // {PCWr, IF_ID_Wr, ID_EX_Wr, EX_MEM_Wr, MEM_WB_Wr, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
    localparam logic [7:0] c_NORMAL = 8'b11111_000;
    localparam logic [7:0] c_LDUSE  = 8'b00111_010;
    localparam logic [7:0] c_REDIR  = 8'b11111_111;
    localparam logic [7:0] c_BUSY   = 8'b00000_000;
    localparam logic [7:0] c_IRQACC = 8'b01111_111;
    localparam logic [7:0] c_DRAIN  = 8'b01111_100;
    localparam logic [7:0] c_VECTOR = 8'b11111_100;
    localparam logic [7:0] c_RESET  = 8'b00000_111;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [3:0]  fwd;
        logic        ack;
        logic        tmo;
        logic [15:0] stall;
    } exp_t;

    logic        clk;
    logic        Reset;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt;
    logic        ID_EX_MemRd;
    logic [4:0]  ID_EX_RdAdress;
    logic        EX_MEM_RegWr;
    logic [4:0]  EX_MEM_RdAdress;
    logic [2:0]  EX_MEM_PCSrc;
    logic        MEM_WB_RegWr;
    logic [4:0]  MEM_WB_RdAdress;
    logic        MemBusy, IRQ;
    logic        PCWr, IF_ID_Wr, ID_EX_Wr, EX_MEM_Wr, MEM_WB_Wr;
    logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush;
    logic [1:0]  ForwardA, ForwardB;
    logic        IRQ_Ack, MemTimeout;
    logic [15:0] StallCount;

    int          n_total = 0;
    int          n_bad   = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] tb_stall = 16'd0;
    logic        tb_tmo   = 1'b0;
    int          busy_run = 0;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .WAIT_MAX(64)) u_dut (
        .clk            (clk),
        .Reset          (Reset),
        .IF_ID_Rs       (IF_ID_Rs),
        .IF_ID_Rt       (IF_ID_Rt),
        .ID_EX_Rs       (ID_EX_Rs),
        .ID_EX_Rt       (ID_EX_Rt),
        .ID_EX_MemRd    (ID_EX_MemRd),
        .ID_EX_RdAdress (ID_EX_RdAdress),
        .EX_MEM_RegWr   (EX_MEM_RegWr),
        .EX_MEM_RdAdress(EX_MEM_RdAdress),
        .EX_MEM_PCSrc   (EX_MEM_PCSrc),
        .MEM_WB_RegWr   (MEM_WB_RegWr),
        .MEM_WB_RdAdress(MEM_WB_RdAdress),
        .MemBusy        (MemBusy),
        .IRQ            (IRQ),
        .PCWr           (PCWr),
        .IF_ID_Wr       (IF_ID_Wr),
        .ID_EX_Wr       (ID_EX_Wr),
        .EX_MEM_Wr      (EX_MEM_Wr),
        .MEM_WB_Wr      (MEM_WB_Wr),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .EX_MEM_Flush   (EX_MEM_Flush),
        .ForwardA       (ForwardA),
        .ForwardB       (ForwardB),
        .IRQ_Ack        (IRQ_Ack),
        .MemTimeout     (MemTimeout),
        .StallCount     (StallCount)
    );

    // Posedges at 10, 20, ...; negedges at 5, 15, ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Push this cycle's expectation, advance the bench's own counters, move on.
    task automatic step(input logic [7:0] ctl, input logic [3:0] fwd, input logic ack);
        exp_t e;
        e.ctl   = ctl;
        e.fwd   = fwd;
        e.ack   = ack;
        e.tmo   = tb_tmo;
        e.stall = tb_stall;
        sb_q.push_back(e);
        if (!ctl[7] && tb_stall != 16'hFFFF) tb_stall = tb_stall + 16'd1;
        if (MemBusy) begin
            busy_run++;
            if (busy_run >= 64) tb_tmo = 1'b1;
        end else begin
            busy_run = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_EX_Rs = 5'd0; ID_EX_Rt = 5'd0;
        ID_EX_MemRd = 1'b0; ID_EX_RdAdress = 5'd0;
        EX_MEM_RegWr = 1'b0; EX_MEM_RdAdress = 5'd0; EX_MEM_PCSrc = 3'd0;
        MEM_WB_RegWr = 1'b0; MEM_WB_RdAdress = 5'd0;
        MemBusy = 1'b0; IRQ = 1'b0;
    endtask

    // Monitor: compare popped expectation against outputs mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("ctl", {24'd0, PCWr, IF_ID_Wr, ID_EX_Wr, EX_MEM_Wr, MEM_WB_Wr,
                        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}, {24'd0, mon_e.ctl});
            chk("fwd",   {28'd0, ForwardA, ForwardB}, {28'd0, mon_e.fwd});
            chk("ack",   {31'd0, IRQ_Ack},    {31'd0, mon_e.ack});
            chk("tmo",   {31'd0, MemTimeout}, {31'd0, mon_e.tmo});
            chk("stall", {16'd0, StallCount}, {16'd0, mon_e.stall});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        Reset = 1'b1;
        // Reset phase: forwarding inputs are set so the forced 00 is observable.
        EX_MEM_RegWr = 1'b1; EX_MEM_RdAdress = 5'd9; ID_EX_Rs = 5'd9; ID_EX_Rt = 5'd9;
        #5  Reset = 1'b0;
        #3;
        chk("rst_ctl", {24'd0, PCWr, IF_ID_Wr, ID_EX_Wr, EX_MEM_Wr, MEM_WB_Wr,
                        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}, {24'd0, c_RESET});
        chk("rst_fwd",   {28'd0, ForwardA, ForwardB}, 32'd0);
        chk("rst_ack",   {31'd0, IRQ_Ack}, 32'd0);
        chk("rst_stall", {16'd0, StallCount}, 32'd0);
        chk("rst_tmo",   {31'd0, MemTimeout}, 32'd0);
        clear_inputs();
        #7  Reset = 1'b1;
        @(posedge clk);
        #1;

        // Plain run after release.
        step(c_NORMAL, 4'b0000, 1'b0);

        // Load-use on rs: single stall cycle, then the load has moved on.
        ID_EX_MemRd = 1'b1; ID_EX_RdAdress = 5'd14; IF_ID_Rs = 5'd14;
        step(c_LDUSE, 4'b0000, 1'b0);
        ID_EX_MemRd = 1'b0;
        step(c_NORMAL, 4'b0000, 1'b0);
        // Load to $0 never stalls.
        ID_EX_MemRd = 1'b1; ID_EX_RdAdress = 5'd0; IF_ID_Rs = 5'd0;
        step(c_NORMAL, 4'b0000, 1'b0);
        // Load-use via rt.
        ID_EX_RdAdress = 5'd7; IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd7;
        step(c_LDUSE, 4'b0000, 1'b0);
        clear_inputs();

        // Forwarding priority and register-0 guard.
        EX_MEM_RegWr = 1'b1; EX_MEM_RdAdress = 5'd9;
        MEM_WB_RegWr = 1'b1; MEM_WB_RdAdress = 5'd9;
        ID_EX_Rs = 5'd9; ID_EX_Rt = 5'd3;
        step(c_NORMAL, 4'b1000, 1'b0);
        EX_MEM_RegWr = 1'b0;
        step(c_NORMAL, 4'b0100, 1'b0);
        ID_EX_Rt = 5'd9;
        step(c_NORMAL, 4'b0101, 1'b0);
        EX_MEM_RegWr = 1'b1; EX_MEM_RdAdress = 5'd3; ID_EX_Rs = 5'd3;
        step(c_NORMAL, 4'b1001, 1'b0);
        EX_MEM_RdAdress = 5'd0; MEM_WB_RdAdress = 5'd0; ID_EX_Rs = 5'd0; ID_EX_Rt = 5'd0;
        step(c_NORMAL, 4'b0000, 1'b0);
        clear_inputs();

        // Redirect overrides a simultaneous load-use.
        EX_MEM_PCSrc = 3'd3;
        ID_EX_MemRd = 1'b1; ID_EX_RdAdress = 5'd14; IF_ID_Rs = 5'd14;
        step(c_REDIR, 4'b0000, 1'b0);
        clear_inputs();
        step(c_NORMAL, 4'b0000, 1'b0);

        // Memory busy for WAIT_MAX cycles, then ready: timeout stays set.
        MemBusy = 1'b1;
        for (int i = 0; i < 64; i++) step(c_BUSY, 4'b0000, 1'b0);
        MemBusy = 1'b0;
        step(c_NORMAL, 4'b0000, 1'b0);
        step(c_NORMAL, 4'b0000, 1'b0);

        // IRQ is held off by load-use, then accepted.
        IRQ = 1'b1;
        ID_EX_MemRd = 1'b1; ID_EX_RdAdress = 5'd5; IF_ID_Rt = 5'd5;
        step(c_LDUSE, 4'b0000, 1'b0);
        ID_EX_MemRd = 1'b0;
        step(c_IRQACC, 4'b0000, 1'b0);
        step(c_DRAIN, 4'b0000, 1'b0);
        // Busy pulse mid-drain pauses the drain counter.
        MemBusy = 1'b1;
        step(c_BUSY, 4'b0000, 1'b0);
        step(c_BUSY, 4'b0000, 1'b0);
        MemBusy = 1'b0;
        step(c_DRAIN, 4'b0000, 1'b0);
        step(c_DRAIN, 4'b0000, 1'b0);
        step(c_VECTOR, 4'b0000, 1'b1);
        IRQ = 1'b0;
        step(c_NORMAL, 4'b0000, 1'b0);
        step(c_NORMAL, 4'b0000, 1'b0);

        @(negedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
